data_island_stream_serializer: RTL and testbench

Generalised HDMI data-island serializer. It buffers complete packets (header plus four subpackets) in an internal FIFO and emits whole data islands of 1..MAX_PACKETS back-to-back 32-clock packets on three 4-bit TERC4 symbol lanes. BCH ECC is generated internally with correct data/ECC boundaries: header data on clocks 0-23, subpacket data on clocks 0-27. It substitutes null packets on underrun. It sits between the packet assemblers (AVI, audio) and the TERC4 encoders/island timing generator.

---
 rtl/hdmi_island_pkg.sv | 26 ++
 rtl/bch_ecc_lfsr.sv | 32 +++
 rtl/data_island_stream_serializer.sv | 163 ++++++++++++++++
 tb/tb_data_island_stream_serializer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_island_pkg.sv
// Shared constants, FSM state and packet payload type for the HDMI data-island serializer.
package hdmi_island_pkg;

  localparam int unsigned PACKET_CLOCKS       = 32;
  localparam int unsigned HEADER_DATA_BITS    = 24;
  localparam int unsigned SUBPACKET_DATA_BITS = 56;
  localparam int unsigned SUBPACKETS          = 4;
  localparam int unsigned ECC_BITS            = 8;
  localparam logic [ECC_BITS-1:0] BCH_POLY    = 8'h83;

  typedef enum logic {IDLE, SEND} state_t;

  typedef struct packed {
    logic [SUBPACKETS*SUBPACKET_DATA_BITS-1:0] subpackets;
    logic [HEADER_DATA_BITS-1:0]               header;
  } packet_t;

  // One LFSR step of the x^8+x^7+x^6+1 BCH generator, LSB-first shift.
  function automatic logic [ECC_BITS-1:0] bch_step(input logic [ECC_BITS-1:0] ecc,
                                                   input logic bit_in);
    logic fb;
    fb = ecc[0] ^ bit_in;
    return (ecc >> 1) ^ (fb ? BCH_POLY : '0);
  endfunction

endpackage

// File: rtl/bch_ecc_lfsr.sv
// BCH parity accumulator; absorbs BITS_PER_CLOCK bits per enabled clock, lowest bit first.
module bch_ecc_lfsr
  import hdmi_island_pkg::*;
#(
  parameter int unsigned BITS_PER_CLOCK = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      enable,
  input  logic [BITS_PER_CLOCK-1:0] data,
  output logic [ECC_BITS-1:0]       ecc
);

  logic [ECC_BITS-1:0] next_ecc;

  // Clear restarts from zero so the first bit of a packet is absorbed in the same clock.
  always_comb begin
    next_ecc = clear ? '0 : ecc;
    if (enable) begin
      for (int i = 0; i < int'(BITS_PER_CLOCK); i++) begin
        next_ecc = bch_step(next_ecc, data[i]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) ecc <= '0;
    else       ecc <= next_ecc;
  end

endmodule

// File: rtl/data_island_stream_serializer.sv
// Packet FIFO plus island sequencer that streams header/subpacket bits and BCH parity
// onto three TERC4 symbol lanes, substituting null packets when the FIFO runs dry.
module data_island_stream_serializer
  import hdmi_island_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned MAX_PACKETS = 18
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         packetValid,
  output logic         packetReady,
  input  logic [23:0]  packetHeader,
  input  logic [223:0] packetSubpackets,
  input  logic         islandStart,
  input  logic [4:0]   islandPacketCount,
  input  logic         hsync,
  input  logic         vsync,
  output logic [3:0]   terc4channel0,
  output logic [3:0]   terc4channel1,
  output logic [3:0]   terc4channel2,
  output logic         islandActive,
  output logic         islandDone,
  output logic         startError,
  output logic         underrun
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [4:0]  LAST_CLOCK = 5'(PACKET_CLOCKS - 1);
  localparam logic [4:0]  HDR_END    = 5'(HEADER_DATA_BITS);
  localparam logic [4:0]  SUB_END    = 5'(SUBPACKET_DATA_BITS / 2);

  packet_t            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   fifo_count, fifo_count_next;
  state_t             state;
  logic [4:0]         clock_count, remaining, cc;
  packet_t            cur_reg, pkt;

  logic start_ok, emitting, emit_first, fifo_empty, do_pop, do_push;
  logic hdr_en, hdr_data, hdr_bit;
  logic [1:0] ecc_sel;
  logic [ECC_BITS-1:0] hdr_ecc;
  logic [ECC_BITS-1:0] sub_ecc [SUBPACKETS];
  logic [1:0] sub_bits [SUBPACKETS];
  logic [SUBPACKET_DATA_BITS-1:0] sp [SUBPACKETS];
  logic [3:0] lane1_c, lane2_c;

  // Symbol source: the FIFO head (or a null packet) on clock 0, the held packet afterwards.
  always_comb begin
    start_ok   = islandStart && (islandPacketCount != 5'd0) &&
                 (islandPacketCount <= 5'(MAX_PACKETS));
    emitting   = (state == SEND) || start_ok;
    emit_first = (state == SEND) ? (clock_count == 5'd0) : start_ok;
    cc         = (state == SEND) ? clock_count : 5'd0;
    fifo_empty = (fifo_count == '0);
    pkt        = cur_reg;
    if (emit_first) pkt = fifo_empty ? '0 : fifo_mem[rd_ptr];
    do_pop     = emit_first && !fifo_empty;
    do_push    = packetValid && packetReady;
    fifo_count_next = fifo_count + CNT_W'(do_push) - CNT_W'(do_pop);

    hdr_en   = emitting && (cc < HDR_END);
    hdr_data = pkt.header[cc];
    hdr_bit  = (cc < HDR_END) ? hdr_data : hdr_ecc[3'(cc - HDR_END)];
    ecc_sel  = 2'(cc - SUB_END);
    for (int n = 0; n < int'(SUBPACKETS); n++) begin
      sp[n]       = pkt.subpackets[n*SUBPACKET_DATA_BITS +: SUBPACKET_DATA_BITS];
      sub_bits[n] = {sp[n][{cc, 1'b1}], sp[n][{cc, 1'b0}]};
      lane1_c[n]  = (cc < SUB_END) ? sub_bits[n][0] : sub_ecc[n][{ecc_sel, 1'b0}];
      lane2_c[n]  = (cc < SUB_END) ? sub_bits[n][1] : sub_ecc[n][{ecc_sel, 1'b1}];
    end
  end

  bch_ecc_lfsr #(.BITS_PER_CLOCK(1)) u_hdr_ecc (
    .clock(clock), .reset(reset), .clear(emit_first), .enable(hdr_en),
    .data(hdr_data), .ecc(hdr_ecc)
  );

  for (genvar n = 0; n < int'(SUBPACKETS); n++) begin : g_sub_ecc
    bch_ecc_lfsr #(.BITS_PER_CLOCK(2)) u_sub_ecc (
      .clock(clock), .reset(reset), .clear(emit_first),
      .enable(emitting && (cc < SUB_END)), .data(sub_bits[n]), .ecc(sub_ecc[n])
    );
  end

  always_ff @(posedge clock) begin
    if (do_push) fifo_mem[wr_ptr] <= '{subpackets: packetSubpackets, header: packetHeader};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      packetReady   <= 1'b1;
      state         <= IDLE;
      clock_count   <= '0;
      remaining     <= '0;
      cur_reg       <= '0;
      terc4channel0 <= '0;
      terc4channel1 <= '0;
      terc4channel2 <= '0;
      islandActive  <= 1'b0;
      islandDone    <= 1'b0;
      startError    <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count  <= fifo_count_next;
      packetReady <= (fifo_count_next != CNT_W'(FIFO_DEPTH));

      terc4channel0 <= {2'b00, vsync, hsync};
      terc4channel1 <= '0;
      terc4channel2 <= '0;
      islandActive  <= 1'b0;
      islandDone    <= 1'b0;
      startError    <= 1'b0;
      underrun      <= 1'b0;

      if (emitting) begin
        terc4channel0 <= {(cc != 5'd0), hdr_bit, vsync, hsync};
        terc4channel1 <= lane1_c;
        terc4channel2 <= lane2_c;
        islandActive  <= 1'b1;
      end
      if (emit_first) begin
        cur_reg  <= pkt;
        underrun <= fifo_empty;
      end

      case (state)
        IDLE: begin
          if (start_ok) begin
            state       <= SEND;
            clock_count <= 5'd1;
            remaining   <= islandPacketCount;
          end else if (islandStart) begin
            startError <= 1'b1;
          end
        end
        SEND: begin
          startError <= islandStart;
          if (clock_count == LAST_CLOCK) begin
            clock_count <= '0;
            if (remaining > 5'd1) begin
              remaining <= remaining - 5'd1;
            end else begin
              state      <= IDLE;
              islandDone <= 1'b1;
            end
          end else begin
            clock_count <= clock_count + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_island_stream_serializer.sv
// Directed bench for the data-island serializer: captures island symbols and compares
// them against an independent BCH/lane-mapping reference.
module tb_data_island_stream_serializer;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         packetValid = 1'b0;
  logic         packetReady;
  logic [23:0]  packetHeader = '0;
  logic [223:0] packetSubpackets = '0;
  logic         islandStart = 1'b0;
  logic [4:0]   islandPacketCount = '0;
  logic         hsync = 1'b0;
  logic         vsync = 1'b0;
  logic [3:0]   terc4channel0, terc4channel1, terc4channel2;
  logic         islandActive, islandDone, startError, underrun;

  always #5 clock = ~clock;

  data_island_stream_serializer dut (
    .clock(clock), .reset(reset), .packetValid(packetValid), .packetReady(packetReady),
    .packetHeader(packetHeader), .packetSubpackets(packetSubpackets),
    .islandStart(islandStart), .islandPacketCount(islandPacketCount),
    .hsync(hsync), .vsync(vsync),
    .terc4channel0(terc4channel0), .terc4channel1(terc4channel1),
    .terc4channel2(terc4channel2), .islandActive(islandActive),
    .islandDone(islandDone), .startError(startError), .underrun(underrun)
  );

  int checks = 0;
  int passed = 0;

  logic [3:0]   cap0 [0:199];
  logic [3:0]   cap1 [0:199];
  logic [3:0]   cap2 [0:199];
  logic         cap_act [0:199];
  logic         cap_done [0:199];
  logic         cap_und [0:199];
  logic         cap_serr [0:199];
  logic [1:0]   hv [0:200];
  logic [23:0]  exp_h [0:3];
  logic [223:0] exp_s [0:3];

  function automatic logic [7:0] bch(input logic [63:0] d, input int n);
    logic [7:0] e;
    logic fb;
    e = '0;
    for (int i = 0; i < n; i++) begin
      fb = e[0] ^ d[i];
      e  = {1'b0, e[7:1]} ^ (fb ? 8'h83 : 8'h00);
    end
    return e;
  endfunction

  // Expected {lane2, lane1, lane0[3:2]} for clock k of a packet.
  function automatic logic [9:0] exp_sym(input logic [23:0] h, input logic [223:0] s, input int k);
    logic [7:0]  e;
    logic [55:0] sp;
    logic [3:0]  l1, l2;
    logic        b2;
    e  = bch(64'(h), 24);
    b2 = (k < 24) ? h[k] : e[k-24];
    for (int n = 0; n < 4; n++) begin
      sp = s[56*n +: 56];
      e  = bch(64'(sp), 56);
      if (k < 28) begin
        l1[n] = sp[2*k];
        l2[n] = sp[2*k+1];
      end else begin
        l1[n] = e[2*(k-28)];
        l2[n] = e[2*(k-28)+1];
      end
    end
    return {l2, l1, (k != 0), b2};
  endfunction

  function automatic int sym_errors(input int cnt);
    int errs;
    errs = 0;
    for (int i = 0; i < 32*cnt; i++) begin
      if ({cap2[i], cap1[i], cap0[i][3:2]} !== exp_sym(exp_h[i/32], exp_s[i/32], i%32) ||
          cap0[i][1:0] !== hv[i] || cap_act[i] !== 1'b1) errs++;
    end
    return errs;
  endfunction

  function automatic int pulse_errors(input int sel, input int n, input int p0, input int p1);
    int errs;
    logic v;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      case (sel)
        0:       v = cap_done[i];
        1:       v = cap_und[i];
        default: v = cap_serr[i];
      endcase
      if (v !== (i == p0 || i == p1)) errs++;
    end
    return errs;
  endfunction

  task automatic push(input logic [23:0] h, input logic [223:0] s);
    packetValid = 1'b1;
    packetHeader = h;
    packetSubpackets = s;
    @(negedge clock);
    packetValid = 1'b0;
  endtask

  task automatic start_island(input logic [4:0] cnt);
    islandStart = 1'b1;
    islandPacketCount = cnt;
    @(negedge clock);
    islandStart = 1'b0;
  endtask

  // Records n output cycles; toggles sync inputs and optionally pokes islandStart at index poke.
  task automatic capture(input int n, input int poke);
    hv[0] = {vsync, hsync};
    for (int i = 0; i < n; i++) begin
      cap0[i] = terc4channel0; cap1[i] = terc4channel1; cap2[i] = terc4channel2;
      cap_act[i] = islandActive; cap_done[i] = islandDone;
      cap_und[i] = underrun; cap_serr[i] = startError;
      {vsync, hsync} = 2'($urandom);
      hv[i+1] = {vsync, hsync};
      islandStart = (i == poke);
      @(negedge clock);
    end
    islandStart = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++;
    if ({terc4channel0, terc4channel1, terc4channel2, islandActive, islandDone, startError, underrun} !== 16'h0)
      $display("FAIL reset_outputs got %h want 0", {terc4channel0, terc4channel1, terc4channel2,
               islandActive, islandDone, startError, underrun});
    else passed++;
    checks++;
    if (packetReady !== 1'b1) $display("FAIL reset_ready got %b want 1", packetReady);
    else passed++;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_zero_packet();
    exp_h[0] = '0; exp_s[0] = '0;
    push('0, '0);
    start_island(5'd1);
    capture(34, -1);
    checks++;
    if (sym_errors(1) !== 0) $display("FAIL zero_symbols got %0d bad want 0", sym_errors(1));
    else passed++;
    checks++;
    if (pulse_errors(0, 34, 31, 31) !== 0) $display("FAIL zero_done got %0d bad want 0", pulse_errors(0, 34, 31, 31));
    else passed++;
    checks++;
    if ({cap_act[32], cap0[32], cap1[32], cap2[32]} !== {1'b0, 2'b00, hv[32], 8'h00})
      $display("FAIL zero_idle got %b want %b", {cap_act[32], cap0[32], cap1[32], cap2[32]},
               {1'b0, 2'b00, hv[32], 8'h00});
    else passed++;
  endtask

  task automatic test_ecc();
    logic [7:0] hecc, s0ecc, s3ecc;
    exp_h[0] = 24'h000084;
    exp_s[0] = {56'h0123_4567_89ABCD, 56'h0, 56'h0, 56'h1};
    push(exp_h[0], exp_s[0]);
    start_island(5'd1);
    capture(33, -1);
    for (int i = 0; i < 8; i++) hecc[i] = cap0[24+i][2];
    for (int j = 0; j < 4; j++) begin
      {s0ecc[2*j+1], s0ecc[2*j]} = {cap2[28+j][0], cap1[28+j][0]};
      {s3ecc[2*j+1], s3ecc[2*j]} = {cap2[28+j][3], cap1[28+j][3]};
    end
    checks++;
    if (hecc !== 8'hD4) $display("FAIL header_ecc got %h want d4", hecc);
    else passed++;
    checks++;
    if (s0ecc !== bch(64'h1, 56) || s0ecc === 8'h00) $display("FAIL sub0_ecc got %h want %h", s0ecc, bch(64'h1, 56));
    else passed++;
    checks++;
    if (s3ecc !== bch(64'(exp_s[0][223:168]), 56)) $display("FAIL sub3_ecc got %h want %h", s3ecc, bch(64'(exp_s[0][223:168]), 56));
    else passed++;
    checks++;
    if (sym_errors(1) !== 0) $display("FAIL ecc_symbols got %0d bad want 0", sym_errors(1));
    else passed++;
  endtask

  task automatic test_back_to_back();
    int act;
    for (int p = 0; p < 3; p++) begin
      exp_h[p] = 24'h82020D + 24'(p);
      exp_s[p] = {7{32'h13579BDF ^ 32'(p * 32'h11111111)}};
      push(exp_h[p], exp_s[p]);
    end
    start_island(5'd3);
    capture(98, -1);
    act = 0;
    for (int i = 0; i < 98; i++) act += int'(cap_act[i]);
    checks++;
    if (sym_errors(3) !== 0) $display("FAIL b2b_symbols got %0d bad want 0", sym_errors(3));
    else passed++;
    checks++;
    if (act !== 96 || cap_act[96] !== 1'b0) $display("FAIL b2b_active got %0d clocks want 96", act);
    else passed++;
    checks++;
    if (pulse_errors(0, 98, 95, 95) + pulse_errors(1, 98, -1, -1) !== 0)
      $display("FAIL b2b_pulses got %0d bad want 0", pulse_errors(0, 98, 95, 95) + pulse_errors(1, 98, -1, -1));
    else passed++;
  endtask

  task automatic test_fifo_full();
    for (int p = 0; p < 4; p++) begin
      exp_h[p] = 24'hC0FFEE ^ 24'(p << 4);
      exp_s[p] = {7{32'hF00DCAFE + 32'(p)}};
      push(exp_h[p], exp_s[p]);
    end
    checks++;
    if (packetReady !== 1'b0) $display("FAIL full_ready got %b want 0", packetReady);
    else passed++;
    push(24'hBADBAD, {7{32'hBADBAD00}});
    start_island(5'd4);
    capture(130, -1);
    checks++;
    if (sym_errors(4) !== 0 || pulse_errors(1, 130, -1, -1) !== 0)
      $display("FAIL full_order got %0d bad want 0", sym_errors(4) + pulse_errors(1, 130, -1, -1));
    else passed++;
    checks++;
    if (packetReady !== 1'b1) $display("FAIL drained_ready got %b want 1", packetReady);
    else passed++;
  endtask

  task automatic test_underrun();
    for (int p = 0; p < 2; p++) begin exp_h[p] = '0; exp_s[p] = '0; end
    start_island(5'd2);
    capture(66, -1);
    checks++;
    if (pulse_errors(1, 66, 0, 32) !== 0) $display("FAIL underrun_pulses got %0d bad want 0", pulse_errors(1, 66, 0, 32));
    else passed++;
    checks++;
    if (sym_errors(2) !== 0 || pulse_errors(0, 66, 63, 63) !== 0)
      $display("FAIL underrun_island got %0d bad want 0", sym_errors(2) + pulse_errors(0, 66, 63, 63));
    else passed++;
  endtask

  task automatic test_start_error();
    start_island(5'd0);
    checks++;
    if ({startError, islandActive} !== 2'b10) $display("FAIL start_zero got %b want 10", {startError, islandActive});
    else passed++;
    start_island(5'd19);
    checks++;
    if ({startError, islandActive} !== 2'b10) $display("FAIL start_19 got %b want 10", {startError, islandActive});
    else passed++;
    exp_h[0] = 24'h5A5A5A; exp_s[0] = {7{32'h0F1E2D3C}};
    push(exp_h[0], exp_s[0]);
    start_island(5'd1);
    capture(34, 5);
    checks++;
    if (pulse_errors(2, 34, 6, 6) !== 0) $display("FAIL start_in_send got %0d bad want 0", pulse_errors(2, 34, 6, 6));
    else passed++;
    checks++;
    if (sym_errors(1) !== 0 || pulse_errors(0, 34, 31, 31) !== 0 || cap_act[32] !== 1'b0)
      $display("FAIL send_timing got %0d bad want 0", sym_errors(1) + pulse_errors(0, 34, 31, 31));
    else passed++;
  endtask

  task automatic test_mid_reset();
    for (int p = 0; p < 3; p++) push(24'h111111 * 24'(p + 1), {7{32'h77777777}});
    start_island(5'd2);
    capture(40, -1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({terc4channel0, terc4channel1, terc4channel2, islandActive, islandDone, underrun, packetReady} !== 16'h0001)
      $display("FAIL mid_reset got %h want 0001", {terc4channel0, terc4channel1, terc4channel2,
               islandActive, islandDone, underrun, packetReady});
    else passed++;
    exp_h[0] = '0; exp_s[0] = '0;
    start_island(5'd1);
    capture(33, -1);
    checks++;
    if (pulse_errors(1, 33, 0, 0) !== 0 || sym_errors(1) !== 0)
      $display("FAIL post_reset_null got %0d bad want 0", pulse_errors(1, 33, 0, 0) + sym_errors(1));
    else passed++;
  endtask

  initial begin
    test_reset();
    test_zero_packet();
    test_ecc();
    test_back_to_back();
    test_fifo_full();
    test_underrun();
    test_start_error();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
